// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit.
// Access sizes and FSM states.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RD   = 2'b01,
    S_WR   = 2'b10,
    S_RESP = 2'b11
  } state_t;

endpackage

// File: rtl/load_store_unit_if.sv
// Word-addressed data-memory bus.
// master = load/store unit, slave = memory.
interface load_store_unit_if;

  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic [31:0] ReadData;

  modport master (
    output MemRead, MemWrite,
    output Address, WriteData,
    input  ReadData
  );

  modport slave (
    input  MemRead, MemWrite,
    input  Address, WriteData,
    output ReadData
  );

endinterface

// File: rtl/lsu_lane_mux.sv
// Little-endian lane merge for stores and
// lane extract/extend for loads.
module lsu_lane_mux
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic        sign_ext,
  output logic [31:0] merged,
  output logic [31:0] rdata
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    merged = wdata;
    rdata  = word;
    b      = word[{off, 3'b000} +: 8];
    h      = word[{off[1], 4'b0000} +: 16];
    case (size)
      SZ_BYTE: begin
        merged = word;
        merged[{off, 3'b000} +: 8] = wdata[7:0];
        rdata = {{24{sign_ext & b[7]}}, b};
      end
      SZ_HALF: begin
        merged = word;
        merged[{off[1], 4'b0000} +: 16] = wdata[15:0];
        rdata = {{16{sign_ext & h[15]}}, h};
      end
      default: begin
        merged = wdata;
        rdata  = word;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: word-aligned memory initiator
// with sub-word read-modify-write and extract.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  load_store_unit_if.master mem
);

  localparam logic [31:0] MW = 32'(MEM_WORDS);

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        sext_q, sext_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] word_q, word_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  logic        bad;
  logic [31:0] merged;
  logic [31:0] ext;

  lsu_lane_mux u_mux (
    .word     (word_q),
    .wdata    (wdata_q),
    .size     (size_q),
    .off      (off_q),
    .sign_ext (sext_q),
    .merged   (merged),
    .rdata    (ext)
  );

  always_comb begin
    bad = (size == 2'b11)
        | ((size == SZ_HALF) & addr[0])
        | ((size == SZ_WORD) & (addr[1:0] != 2'b00))
        | ({2'b00, addr[31:2]} >= MW);
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    sext_d  = sext_q;
    off_d   = off_q;
    wdata_d = wdata_q;
    addr_d  = addr_q;
    word_d  = word_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          we_d    = we;
          size_d  = size;
          sext_d  = sign_ext;
          off_d   = addr[1:0];
          wdata_d = wdata;
          addr_d  = {addr[31:2], 2'b00};
          err_d   = bad;
          if (bad)
            state_d = S_RESP;
          else if (we && size == SZ_WORD)
            state_d = S_WR;
          else
            state_d = S_RD;
        end
      end
      S_RD: begin
        word_d  = mem.ReadData;
        state_d = we_q ? S_WR : S_RESP;
      end
      S_WR: state_d = S_RESP;
      S_RESP: begin
        if (!we_q && !err_q)
          rdata_d = ext;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      sext_q  <= 1'b0;
      off_q   <= 2'b00;
      wdata_q <= '0;
      addr_q  <= '0;
      word_q  <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      sext_q  <= sext_d;
      off_q   <= off_d;
      wdata_q <= wdata_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_RESP);
  assign err           = (state_q == S_RESP) & err_q;
  assign rdata         = rdata_q;
  assign mem.MemRead   = (state_q == S_RD);
  assign mem.MemWrite  = (state_q == S_WR);
  assign mem.Address   = addr_q;
  assign mem.WriteData = (state_q == S_WR) ? merged : 32'h0;

endmodule
